// File: rtl/pipe_redirect_ctrl.sv
// Arbitrates exception/execute/decode redirects, flushes the front end, then hands the target to the PFU.
// Optional PIPE_REDIRECT_CTRL_PERF_EN adds saturating stall/flush event counters.
`ifndef PC_WIDHT
`define PC_WIDHT 32
`endif
`ifndef ZERO_PC
`define ZERO_PC {`PC_WIDHT{1'b0}}
`endif

module pipe_redirect_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 exc_valid_i,
    input  logic [`PC_WIDHT-1:0] exc_vector_i,
    input  logic                 exu_redir_valid_i,
    input  logic [`PC_WIDHT-1:0] exu_redir_pc_i,
    input  logic                 dpu_redir_valid_i,
    input  logic [`PC_WIDHT-1:0] dpu_redir_pc_i,
    input  logic                 stall_req_i,
    input  logic                 pfu_redir_ready_i,
    output logic                 pfu_redir_valid_o,
    output logic [`PC_WIDHT-1:0] pfu_redir_pc_o,
    output logic                 flush_o,
    output logic                 stall_o,
    output logic                 busy_o
`ifdef PIPE_REDIRECT_CTRL_PERF_EN
    ,
    output logic [31:0]          stall_cnt_o,
    output logic [31:0]          flush_cnt_o
`endif
);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StFlush    = 2'd1;
    localparam logic [1:0] StRedirect = 2'd2;

    localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES - 1);

    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [1:0]           lvl_q, lvl_d;
    logic [`PC_WIDHT-1:0] pc_q, pc_d;

    logic                 req_any;
    logic [1:0]           win_lvl;
    logic [`PC_WIDHT-1:0] win_pc;
    logic                 preempt;
    logic                 start;

    always_comb begin
        req_any = exc_valid_i | exu_redir_valid_i | dpu_redir_valid_i;
        win_lvl = 2'd0;
        win_pc  = dpu_redir_pc_i;
        if (exc_valid_i) begin
            win_lvl = 2'd2;
            win_pc  = exc_vector_i;
        end else if (exu_redir_valid_i) begin
            win_lvl = 2'd1;
            win_pc  = exu_redir_pc_i;
        end
    end

    // Only a strictly higher level may displace a redirect already in flight.
    assign preempt = (state_q != StIdle) && req_any && (win_lvl > lvl_q);
    assign start   = ((state_q == StIdle) && req_any) || preempt;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lvl_d   = lvl_q;
        pc_d    = pc_q;
        if (start) begin
            state_d = StFlush;
            cnt_d   = FlushInit;
            lvl_d   = win_lvl;
            pc_d    = win_pc;
        end else begin
            case (state_q)
                StFlush: begin
                    if (cnt_q == 4'd0) begin
                        state_d = StRedirect;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                StRedirect: begin
                    if (pfu_redir_ready_i) begin
                        state_d = StIdle;
                    end
                end
                StIdle:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            lvl_q   <= 2'd0;
            pc_q    <= `ZERO_PC;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            pc_q    <= pc_d;
        end
    end

    assign busy_o            = (state_q != StIdle);
    assign flush_o           = (state_q == StFlush);
    assign pfu_redir_valid_o = (state_q == StRedirect);
    assign pfu_redir_pc_o    = pc_q;
    assign stall_o           = stall_req_i | busy_o;

`ifdef PIPE_REDIRECT_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (start && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_redirect_ctrl.sv
// Scoreboard bench for pipe_redirect_ctrl: a timestamp-based reference model predicts per-cycle
// outputs and issued redirect PCs; a negedge monitor compares the DUT against those predictions.
`ifndef PC_WIDHT
`define PC_WIDHT 32
`endif

module tb_pipe_redirect_ctrl;

    localparam int unsigned FC = 2;
    typedef logic [`PC_WIDHT-1:0] pc_t;

    typedef struct {
        logic        flush;
        logic        valid;
        logic        busy;
        logic        stall;
        pc_t         pc;
        int unsigned scnt;
        int unsigned fcnt;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic exc_valid_i = 1'b0, exu_redir_valid_i = 1'b0, dpu_redir_valid_i = 1'b0;
    pc_t  exc_vector_i = '0, exu_redir_pc_i = '0, dpu_redir_pc_i = '0;
    logic stall_req_i = 1'b0, pfu_redir_ready_i = 1'b0;
    logic pfu_redir_valid_o, flush_o, stall_o, busy_o;
    pc_t  pfu_redir_pc_o;
`ifdef PIPE_REDIRECT_CTRL_PERF_EN
    logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

    pipe_redirect_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .exc_valid_i       (exc_valid_i),
        .exc_vector_i      (exc_vector_i),
        .exu_redir_valid_i (exu_redir_valid_i),
        .exu_redir_pc_i    (exu_redir_pc_i),
        .dpu_redir_valid_i (dpu_redir_valid_i),
        .dpu_redir_pc_i    (dpu_redir_pc_i),
        .stall_req_i       (stall_req_i),
        .pfu_redir_ready_i (pfu_redir_ready_i),
        .pfu_redir_valid_o (pfu_redir_valid_o),
        .pfu_redir_pc_o    (pfu_redir_pc_o),
        .flush_o           (flush_o),
        .stall_o           (stall_o),
        .busy_o            (busy_o)
`ifdef PIPE_REDIRECT_CTRL_PERF_EN
        ,
        .stall_cnt_o       (stall_cnt_o),
        .flush_cnt_o       (flush_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    exp_t exp_q[$];
    pc_t  hs_q[$];

    // Reference model: a redirect is "active" from acceptance until handshake; its valid phase
    // starts FC+1 cycles after the accepting cycle.
    bit          m_active = 1'b0;
    int          m_lvl = 0;
    pc_t         m_pc = '0;
    int          m_valid_at = 0;
    int          cyc = 0;
    int unsigned m_scnt = 0;
    int unsigned m_fcnt = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_lvl    = 0;
        m_pc     = '0;
        m_scnt   = 0;
        m_fcnt   = 0;
    endtask

    task automatic step(input bit exc, input pc_t epc, input bit exu, input pc_t xpc,
                        input bit dpu, input pc_t dpc, input bit stl, input bit rdy);
        exp_t e;
        bit   req;
        int   wl;
        pc_t  wpc;
        @(posedge clk_i);
        #1;
        exc_valid_i       = exc;
        exc_vector_i      = epc;
        exu_redir_valid_i = exu;
        exu_redir_pc_i    = xpc;
        dpu_redir_valid_i = dpu;
        dpu_redir_pc_i    = dpc;
        stall_req_i       = stl;
        pfu_redir_ready_i = rdy;

        e.busy  = m_active;
        e.flush = m_active && (cyc < m_valid_at);
        e.valid = m_active && (cyc >= m_valid_at);
        e.stall = stl | m_active;
        e.pc    = m_pc;
        e.scnt  = m_scnt;
        e.fcnt  = m_fcnt;
        exp_q.push_back(e);

        req = exc | exu | dpu;
        wl  = exc ? 2 : (exu ? 1 : 0);
        wpc = exc ? epc : (exu ? xpc : dpc);
        if (e.valid && rdy) hs_q.push_back(m_pc);
        if (e.stall && m_scnt != 32'hFFFF_FFFF) m_scnt++;
        if (req && (!m_active || wl > m_lvl)) begin
            m_active   = 1'b1;
            m_lvl      = wl;
            m_pc       = wpc;
            m_valid_at = cyc + 1 + int'(FC);
            m_fcnt++;
        end else if (e.valid && rdy) begin
            m_active = 1'b0;
        end
        cyc++;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, '0, 0, rdy);
    endtask

    always @(negedge clk_i) begin
        exp_t e;
        pc_t  p;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("flush_o", 64'(flush_o), 64'(e.flush));
            chk("valid_o", 64'(pfu_redir_valid_o), 64'(e.valid));
            chk("busy_o", 64'(busy_o), 64'(e.busy));
            chk("stall_o", 64'(stall_o), 64'(e.stall));
            chk("pc_o", 64'(pfu_redir_pc_o), 64'(e.pc));
`ifdef PIPE_REDIRECT_CTRL_PERF_EN
            chk("stall_cnt_o", 64'(stall_cnt_o), 64'(e.scnt));
            chk("flush_cnt_o", 64'(flush_cnt_o), 64'(e.fcnt));
`endif
        end
        if (pfu_redir_valid_o && pfu_redir_ready_i) begin
            if (hs_q.size() == 0) begin
                chk("unexpected_redirect", 64'(pfu_redir_pc_o), 64'hDEAD);
            end else begin
                p = hs_q.pop_front();
                chk("redirect_pc", 64'(pfu_redir_pc_o), 64'(p));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_flush"}, 64'(flush_o), 64'd0);
        chk({tag, "_valid"}, 64'(pfu_redir_valid_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_pc"}, 64'(pfu_redir_pc_o), 64'd0);
        stall_req_i = 1'b1;
        #1;
        chk({tag, "_stall_hi"}, 64'(stall_o), 64'd1);
        stall_req_i = 1'b0;
        #1;
        chk({tag, "_stall_lo"}, 64'(stall_o), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_reset_outputs("por");
        #5;
        rst_ni = 1'b1;
        model_reset();

        // Single decode redirect, ready tied high.
        step(0, '0, 0, '0, 1, 32'h100, 0, 1);
        idle(5, 1);
        // All three at once: exception wins.
        step(1, 32'h300, 1, 32'h200, 1, 32'h100, 0, 1);
        idle(5, 1);
        // Execute redirect preempts decode redirect during FLUSH.
        step(0, '0, 0, '0, 1, 32'h100, 0, 1);
        step(0, '0, 1, 32'h200, 0, '0, 0, 1);
        idle(6, 1);
        // Stalled handshake, lower-priority request dropped meanwhile.
        step(0, '0, 1, 32'h200, 0, '0, 0, 0);
        idle(3, 0);
        step(0, '0, 0, '0, 1, 32'h140, 0, 0);
        idle(4, 0);
        idle(3, 1);
        // Preemption coinciding with handshake: old PC issued, new one follows.
        step(0, '0, 0, '0, 1, 32'h100, 0, 0);
        idle(3, 0);
        step(1, 32'h300, 0, '0, 0, '0, 0, 1);
        idle(6, 1);
        // Stall request held, then one redirect.
        for (int i = 0; i < 10; i++) step(0, '0, 0, '0, 0, '0, 1, 1);
        step(0, '0, 0, '0, 1, 32'h180, 0, 1);
        idle(5, 1);

        // Asynchronous reset during the second FLUSH cycle.
        step(0, '0, 0, '0, 1, 32'h1C0, 0, 1);
        idle(1, 1);
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        hs_q.delete();
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk_i);
        #3;
        rst_ni = 1'b1;
        model_reset();
        idle(6, 1);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 15) == 0), pc_t'($urandom),
                 ($urandom_range(0, 9) == 0), pc_t'($urandom),
                 ($urandom_range(0, 5) == 0), pc_t'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
        end
        idle(20, 1);
        @(negedge clk_i);
        #1;
        chk("redirects_drained", 64'(hs_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
